// File: rtl/bit_count_unit_pkg.sv
// Shared types for the bit-count unit: operation codes, condition-register field and word type.
package bit_count_unit_pkg;

  localparam int BITCNT_MAX_W = 64;

  typedef enum logic [1:0] {
    BC_CNTLZ  = 2'd0,
    BC_CNTTZ  = 2'd1,
    BC_POPCNT = 2'd2,
    BC_RSVD   = 2'd3
  } Bitcnt_op;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic so;
  } Cr_field;

  typedef logic [BITCNT_MAX_W-1:0] Word;

  // Counts are never negative, so lt is constant; so marks the reserved op.
  function automatic Cr_field make_cr(input logic is_zero, input logic is_rsvd);
    Cr_field cr;
    cr.lt = 1'b0;
    cr.gt = !is_zero;
    cr.eq = is_zero;
    cr.so = is_rsvd;
    return cr;
  endfunction

endpackage

// File: rtl/bit_count_unit_group.sv
// First-level partial counter: leading/trailing zero count, popcount and nonzero flag
// for one GROUP-bit slice of the operand.
module bit_count_group #(
  parameter int GROUP = 8
) (
  input  logic [GROUP-1:0]       x_i,
  output logic [$clog2(GROUP):0] lz_o,
  output logic [$clog2(GROUP):0] tz_o,
  output logic [$clog2(GROUP):0] pop_o,
  output logic                   nz_o
);

  localparam int CW = $clog2(GROUP) + 1;

  // Ascending scan: the highest set bit is written last and decides lz;
  // descending scan: the lowest set bit is written last and decides tz.
  always_comb begin
    lz_o  = CW'(GROUP);
    tz_o  = CW'(GROUP);
    pop_o = '0;
    for (int i = 0; i < GROUP; i++) begin
      if (x_i[i]) begin
        lz_o  = CW'(GROUP - 1 - i);
        pop_o = pop_o + CW'(1);
      end
    end
    for (int i = GROUP - 1; i >= 0; i--) begin
      if (x_i[i]) tz_o = CW'(i);
    end
  end

  assign nz_o = |x_i;

endmodule

// File: rtl/bit_count_unit.sv
// Pipelined CNTLZ/CNTTZ/POPCNT unit with valid/ready handshake, flush and tag pass-through.
// Group counters feed an optional stage-1 register; the reduction feeds the output register.
module bit_count_unit
  import bit_count_unit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  Bitcnt_op         in_op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output Cr_field          out_cr,
  output logic [TAG_W-1:0] out_tag
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // A producer holding valid keeps its payload stable until the transfer; ready never
  // depends on valid of the same interface.

  localparam int NG = WIDTH / GROUP;
  localparam int CW = $clog2(GROUP) + 1;
  localparam int RW = $clog2(WIDTH) + 1;

  if (WIDTH > BITCNT_MAX_W || (WIDTH % GROUP) != 0 || (STAGES != 1 && STAGES != 2)) begin : g_bad_param
    $error("bit_count_unit: unsupported WIDTH/GROUP/STAGES combination");
  end

  logic [NG-1:0][CW-1:0] g_lz, g_tz, g_pop;
  logic [NG-1:0]         g_nz;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    bit_count_group #(.GROUP(GROUP)) u_grp (
      .x_i   (in_x[g*GROUP +: GROUP]),
      .lz_o  (g_lz[g]),
      .tz_o  (g_tz[g]),
      .pop_o (g_pop[g]),
      .nz_o  (g_nz[g])
    );
  end

  logic [NG-1:0][CW-1:0] r_lz, r_tz, r_pop;
  logic [NG-1:0]         r_nz;
  Bitcnt_op              r_op;
  logic [TAG_W-1:0]      r_tag;
  logic                  r_valid;

  logic                  out_valid_q;
  logic [WIDTH-1:0]      out_y_q, out_y_d;
  Cr_field               out_cr_q, out_cr_d;
  logic [TAG_W-1:0]      out_tag_q, out_tag_d;
  logic                  out_adv;

  assign out_adv = !out_valid_q || out_ready;

  if (STAGES == 2) begin : g_two
    logic                  s1_valid_q;
    logic [NG-1:0][CW-1:0] s1_lz_q, s1_tz_q, s1_pop_q;
    logic [NG-1:0]         s1_nz_q;
    Bitcnt_op              s1_op_q;
    logic [TAG_W-1:0]      s1_tag_q;
    logic                  s1_adv;

    assign s1_adv   = !s1_valid_q || out_adv;
    assign in_ready = s1_adv && !flush;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1_valid_q <= 1'b0;
        s1_lz_q    <= '0;
        s1_tz_q    <= '0;
        s1_pop_q   <= '0;
        s1_nz_q    <= '0;
        s1_op_q    <= BC_CNTLZ;
        s1_tag_q   <= '0;
      end else begin
        if (flush) s1_valid_q <= 1'b0;
        else if (s1_adv) s1_valid_q <= in_valid;
        if (in_valid && in_ready) begin
          s1_lz_q  <= g_lz;
          s1_tz_q  <= g_tz;
          s1_pop_q <= g_pop;
          s1_nz_q  <= g_nz;
          s1_op_q  <= in_op;
          s1_tag_q <= in_tag;
        end
      end
    end

    assign r_lz    = s1_lz_q;
    assign r_tz    = s1_tz_q;
    assign r_pop   = s1_pop_q;
    assign r_nz    = s1_nz_q;
    assign r_op    = s1_op_q;
    assign r_tag   = s1_tag_q;
    assign r_valid = s1_valid_q;
  end else begin : g_one
    assign in_ready = out_adv && !flush;
    assign r_lz     = g_lz;
    assign r_tz     = g_tz;
    assign r_pop    = g_pop;
    assign r_nz     = g_nz;
    assign r_op     = in_op;
    assign r_tag    = in_tag;
    assign r_valid  = in_valid;
  end

  logic [RW-1:0] lz_sum, tz_sum, pop_sum, res;
  logic          lz_hit, tz_hit;

  // Zero groups ahead of the first nonzero one contribute a full GROUP each.
  always_comb begin
    lz_sum  = RW'(WIDTH);
    tz_sum  = RW'(WIDTH);
    pop_sum = '0;
    lz_hit  = 1'b0;
    tz_hit  = 1'b0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (!lz_hit && r_nz[g]) begin
        lz_sum = RW'((NG - 1 - g) * GROUP) + RW'(r_lz[g]);
        lz_hit = 1'b1;
      end
    end
    for (int g = 0; g < NG; g++) begin
      if (!tz_hit && r_nz[g]) begin
        tz_sum = RW'(g * GROUP) + RW'(r_tz[g]);
        tz_hit = 1'b1;
      end
      pop_sum = pop_sum + RW'(r_pop[g]);
    end
  end

  always_comb begin
    res = '0;
    case (r_op)
      BC_CNTLZ:  res = lz_sum;
      BC_CNTTZ:  res = tz_sum;
      BC_POPCNT: res = pop_sum;
      BC_RSVD:   res = '0;
      default:   res = '0;
    endcase
    out_y_d   = WIDTH'(res);
    out_cr_d  = make_cr(res == '0, r_op == BC_RSVD);
    out_tag_d = r_tag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_cr_q    <= '0;
      out_tag_q   <= '0;
    end else begin
      if (flush) out_valid_q <= 1'b0;
      else if (out_adv) out_valid_q <= r_valid;
      if (out_adv && r_valid && !flush) begin
        out_y_q   <= out_y_d;
        out_cr_q  <= out_cr_d;
        out_tag_q <= out_tag_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_cr    = out_cr_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_bit_count_unit.sv
// Bench for bit_count_unit: directed vectors on a 32-bit/2-stage and a 64-bit/1-stage
// instance, plus a scoreboarded random run with stalls on the 32-bit instance.
module tb_bit_count_unit;
  import bit_count_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT A: WIDTH=32, STAGES=2 ----------------
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  Bitcnt_op    in_op;
  logic [31:0] in_x, out_y;
  logic [4:0]  in_tag, out_tag;
  Cr_field     out_cr;

  bit_count_unit #(.WIDTH(32), .GROUP(8), .STAGES(2), .TAG_W(5)) u_dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_x(in_x), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_cr(out_cr), .out_tag(out_tag)
  );

  // ---------------- DUT B: WIDTH=64, STAGES=1 ----------------
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  Bitcnt_op    b_in_op;
  logic [63:0] b_in_x, b_out_y;
  logic [4:0]  b_in_tag, b_out_tag;
  Cr_field     b_out_cr;

  bit_count_unit #(.WIDTH(64), .GROUP(8), .STAGES(1), .TAG_W(5)) u_dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op), .in_x(b_in_x), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_y(b_out_y), .out_cr(b_out_cr), .out_tag(b_out_tag)
  );

  localparam logic [3:0] CR_GT = 4'b0100;
  localparam logic [3:0] CR_EQ = 4'b0010;
  localparam logic [3:0] CR_RS = 4'b0011;

  int n_checks = 0;
  int n_errors = 0;
  logic [40:0] exp_q[$];

  // ---------------- scoreboard / checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [40:0] model_a(input Bitcnt_op op, input logic [31:0] x, input logic [4:0] tag);
    int lz, tz, pc;
    logic [31:0] y;
    lz = 32; tz = 32; pc = 0;
    for (int i = 31; i >= 0; i--) if (x[i]) begin lz = 31 - i; break; end
    for (int i = 0; i < 32; i++) if (x[i]) begin tz = i; break; end
    for (int i = 0; i < 32; i++) pc += int'(x[i]);
    case (op)
      BC_CNTLZ:  y = 32'(lz);
      BC_CNTTZ:  y = 32'(tz);
      BC_POPCNT: y = 32'(pc);
      default:   y = 32'd0;
    endcase
    return {tag, 1'b0, (y != 0), (y == 0), (op == BC_RSVD), y};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_a(input string name, input Bitcnt_op op, input logic [31:0] x,
                       input logic [4:0] tag, input logic [31:0] exp_y, input logic [3:0] exp_cr);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_x = x; in_tag = tag; out_ready = 1'b1;
    #1 check({name, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check({name, "_lat_early"}, out_valid, 0);
    @(negedge clk);
    #1;
    check({name, "_valid"}, out_valid, 1);
    check({name, "_y"}, out_y, exp_y);
    check({name, "_cr"}, out_cr, exp_cr);
    check({name, "_tag"}, out_tag, tag);
  endtask

  task automatic run_b(input string name, input Bitcnt_op op, input logic [63:0] x,
                       input logic [4:0] tag, input logic [63:0] exp_y, input logic [3:0] exp_cr);
    @(negedge clk);
    b_in_valid = 1'b1; b_in_op = op; b_in_x = x; b_in_tag = tag; b_out_ready = 1'b1;
    #1;
    check({name, "_in_ready"}, b_in_ready, 1);
    check({name, "_lat_early"}, b_out_valid, 0);
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    check({name, "_valid"}, b_out_valid, 1);
    check({name, "_y"}, b_out_y, exp_y);
    check({name, "_cr"}, b_out_cr, exp_cr);
    check({name, "_tag"}, b_out_tag, tag);
  endtask

  task automatic random_a(input int n_ops);
    int sent, got, cyc;
    logic acc;
    logic [40:0] exp_w;
    sent = 0; got = 0; cyc = 0; acc = 1'b0;
    in_valid = 1'b0;
    while (got < n_ops && cyc < n_ops * 4) begin
      @(negedge clk);
      cyc++;
      if (acc) in_valid = 1'b0;
      if (!in_valid && sent < n_ops && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_op    = Bitcnt_op'($urandom_range(0, 3));
        in_tag   = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 5))
          0:       in_x = 32'h0;
          1:       in_x = 32'hFFFF_FFFF;
          2:       in_x = 32'h1 << $urandom_range(0, 31);
          3:       in_x = $urandom() & $urandom() & $urandom();
          default: in_x = $urandom();
        endcase
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("rand_spurious_out", 64'(exp_q.size()), 1);
        else begin
          exp_w = exp_q.pop_front();
          check("rand_result", {out_tag, out_cr, out_y}, exp_w);
          got++;
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(model_a(in_op, in_x, in_tag));
        sent++;
      end
    end
    in_valid = 1'b0;
    check("rand_all_results", got, n_ops);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] b2b_x[4];
  Bitcnt_op    b2b_op[4];
  logic [31:0] b2b_y[4];

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = BC_CNTLZ; in_x = '0; in_tag = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    b_in_op = BC_CNTLZ; b_in_x = '0; b_in_tag = '0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_cr", out_cr, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_b_out_valid", b_out_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);

    // basic ops and extremes
    run_a("clz_bit16", BC_CNTLZ,  32'h0001_0000, 5'd1, 32'd15, CR_GT);
    run_a("ctz_bit16", BC_CNTTZ,  32'h0001_0000, 5'd2, 32'd16, CR_GT);
    run_a("pop_f0f0",  BC_POPCNT, 32'hF0F0_0001, 5'd3, 32'd9,  CR_GT);
    run_a("clz_zero",  BC_CNTLZ,  32'h0,         5'd4, 32'd32, CR_GT);
    run_a("ctz_zero",  BC_CNTTZ,  32'h0,         5'd5, 32'd32, CR_GT);
    run_a("pop_zero",  BC_POPCNT, 32'h0,         5'd6, 32'd0,  CR_EQ);
    run_a("ctz_ones",  BC_CNTTZ,  32'hFFFF_FFFF, 5'd7, 32'd0,  CR_EQ);
    run_a("clz_ones",  BC_CNTLZ,  32'hFFFF_FFFF, 5'd8, 32'd0,  CR_EQ);
    run_a("pop_ones",  BC_POPCNT, 32'hFFFF_FFFF, 5'd9, 32'd32, CR_GT);
    run_a("rsvd_op",   BC_RSVD,   32'h1234_5678, 5'd10, 32'd0, CR_RS);

    // back-to-back with tags 1..4
    b2b_op[0] = BC_CNTLZ;  b2b_x[0] = 32'h8000_0000; b2b_y[0] = 32'd0;
    b2b_op[1] = BC_CNTTZ;  b2b_x[1] = 32'h0000_0100; b2b_y[1] = 32'd8;
    b2b_op[2] = BC_POPCNT; b2b_x[2] = 32'h0000_00FF; b2b_y[2] = 32'd8;
    b2b_op[3] = BC_CNTLZ;  b2b_x[3] = 32'h0000_0001; b2b_y[3] = 32'd31;
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 4) begin
        in_valid = 1'b1; in_op = b2b_op[k]; in_x = b2b_x[k]; in_tag = 5'(k + 1);
      end else in_valid = 1'b0;
      #1;
      if (k < 4) check("b2b_in_ready", in_ready, 1);
      if (k >= 2 && k < 6) begin
        check("b2b_valid", out_valid, 1);
        check("b2b_tag", out_tag, 5'(k - 1));
        check("b2b_y", out_y, b2b_y[k - 2]);
      end
      if (k == 6) check("b2b_drained", out_valid, 0);
    end

    // back-pressure: out_ready low for 5 cycles with 3 ops offered
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = BC_CNTLZ; in_x = 32'h0000_1000; in_tag = 5'd7;
    #1 check("bp_accept1", in_ready, 1);
    @(negedge clk);
    in_op = BC_CNTTZ; in_tag = 5'd8;
    #1 check("bp_accept2", in_ready, 1);
    @(negedge clk);
    in_op = BC_POPCNT; in_tag = 5'd9;
    #1;
    check("bp_in_ready_drop", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1 check("bp_in_ready_low", in_ready, 0);
      end
      check("bp_stable_y", out_y, 32'd19);
      check("bp_stable_tag", out_tag, 5'd7);
      check("bp_stable_cr", out_cr, CR_GT);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    check("bp_r1_tag", out_tag, 5'd7);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("bp_r2_valid", out_valid, 1);
    check("bp_r2_tag", out_tag, 5'd8);
    check("bp_r2_y", out_y, 32'd12);
    @(negedge clk);
    #1;
    check("bp_r3_valid", out_valid, 1);
    check("bp_r3_tag", out_tag, 5'd9);
    check("bp_r3_y", out_y, 32'd1);
    @(negedge clk);
    #1 check("bp_no_dup", out_valid, 0);

    // flush with two ops in flight
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = BC_POPCNT; in_x = 32'h0000_000F; in_tag = 5'd20;
    @(negedge clk);
    in_tag = 5'd21;
    @(negedge clk);
    flush = 1'b1; in_tag = 5'd22;
    #1 check("fl_inflight", out_valid, 1);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("fl_cleared", out_valid, 0);
    check("fl_in_ready_low", in_ready, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 check("fl_no_result", out_valid, 0);
      @(negedge clk);
    end

    // asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = BC_CNTLZ; in_x = 32'h0000_0010; in_tag = 5'd30;
    @(negedge clk);
    in_tag = 5'd31;
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("rs_stalled", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("rs_async_valid", out_valid, 0);
    check("rs_async_y", out_y, 0);
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b1;
    #1 check("rs_in_ready", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check("rs_no_pulse", out_valid, 0);
    end

    // 64-bit, single-stage instance
    run_b("b_clz_one",  BC_CNTLZ,  64'h1,                   5'd1, 64'd63, CR_GT);
    run_b("b_ctz_msb",  BC_CNTTZ,  64'h8000_0000_0000_0000, 5'd2, 64'd63, CR_GT);
    run_b("b_pop_ones", BC_POPCNT, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'd64, CR_GT);
    run_b("b_clz_zero", BC_CNTLZ,  64'h0,                   5'd4, 64'd64, CR_GT);
    run_b("b_ctz_mid",  BC_CNTTZ,  64'h0000_0100_0000_0000, 5'd5, 64'd40, CR_GT);
    run_b("b_pop_zero", BC_POPCNT, 64'h0,                   5'd6, 64'd0,  CR_EQ);

    // random ops with random output stalls
    random_a(10000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
